mult_ctrl_taint_param: RTL and testbench

//  Parametrised, constant-time control FSM for the shift-add sequential multiplier with taint tracking.

---
 rtl/mult_taint_pkg.sv | 18 +
 rtl/mult_taint_sticky.sv | 28 ++
 rtl/mult_ctrl_taint_param.sv | 164 ++++++++++++++++
 tb/tb_mult_ctrl_taint_param.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mult_taint_pkg.sv
// Shared definitions for the taint-tracking shift-add multiplier:
// controller state encoding and the taint combine helper.
package mult_taint_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] INIT  = 3'd1;
    localparam logic [STATE_W-1:0] BIT   = 3'd2;
    localparam logic [STATE_W-1:0] SHIFT = 3'd3;
    localparam logic [STATE_W-1:0] DONE  = 3'd4;

    // Taint propagates if either contributing signal is tainted.
    function automatic logic taint_or(input logic a, input logic b);
        return a | b;
    endfunction

endpackage

// File: rtl/mult_taint_sticky.sv
// One-bit sticky taint flag: once set it holds until an explicit clear or reset.
// A clear and a set in the same cycle leave the flag equal to the set value.
module mult_taint_sticky (
    input  logic clk,
    input  logic rst_n,
    input  logic set_i,
    input  logic clr_i,
    output logic q_o
);

    logic q_q;
    logic q_d;

    assign q_d = (clr_i ? 1'b0 : q_q) | set_i;

    // NOTE: sequential state uses non-blocking assignments only; blocking here
    // would create ordering races with other clocked processes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/mult_ctrl_taint_param.sv
// Constant-time control FSM for the shift-add multiplier with shadow taint outputs.
// Define MULT_TAINT_EN to build the taint logic; otherwise every *_t output is tied to 0.
module mult_ctrl_taint_param
    import mult_taint_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             start_t,
    input  logic             abort,
    input  logic             abort_t,
    input  logic             signed_mode,
    input  logic             signed_mode_t,
    input  logic             taint_clr,
    input  logic [WIDTH-1:0] multiplierReg,
    input  logic [WIDTH-1:0] multiplierReg_t,
    output logic             busy,
    output logic             busy_t,
    output logic             productDone,
    output logic             productDone_t,
    output logic             rsload,
    output logic             rsload_t,
    output logic             rssub,
    output logic             rssub_t,
    output logic             rsclear,
    output logic             rsclear_t,
    output logic             rsshr,
    output logic             rsshr_t,
    output logic             mrld,
    output logic             mrld_t,
    output logic             mdld,
    output logic             mdld_t
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sgn_q, sgn_d;

    logic accept;
    logic last_bit;
    logic in_bit;
    logic cur_bit;
    logic msb_sub;

    assign accept   = (state_q == IDLE) & start & ~abort;
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    assign in_bit   = (state_q == BIT);
    assign cur_bit  = multiplierReg[cnt_q];
    assign msb_sub  = sgn_q & last_bit;

    // NOTE: every variable written here gets a default first, so no path can
    // infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = INIT;
                    sgn_d   = signed_mode;
                end
            end
            INIT: begin
                cnt_d   = '0;
                state_d = BIT;
            end
            BIT:   state_d = SHIFT;
            SHIFT: begin
                if (last_bit) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = BIT;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort overrides whatever transition the schedule wanted.
        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
        end
    end

    // Strobes decode directly from state so an async reset clears them at once.
    assign busy        = (state_q != IDLE);
    assign productDone = (state_q == DONE);
    assign rsload      = in_bit & cur_bit & ~msb_sub;
    assign rssub       = in_bit & cur_bit & msb_sub;
    assign rsclear     = (state_q == INIT);
    assign mrld        = (state_q == INIT);
    assign mdld        = (state_q == INIT);
    assign rsshr       = (state_q == SHIFT);

`ifdef MULT_TAINT_EN
    logic ctrl_t, sgn_t;
    logic ctrl_set, sgn_set, clr_ok;
    logic strobe_t;

    assign clr_ok   = (state_q == IDLE) & taint_clr;
    assign ctrl_set = (accept & start_t) | (abort & abort_t);
    assign sgn_set  = accept & signed_mode_t;

    mult_taint_sticky u_ctrl_t (
        .clk   (clk),
        .rst_n (rst_n),
        .set_i (ctrl_set),
        .clr_i (clr_ok),
        .q_o   (ctrl_t)
    );

    mult_taint_sticky u_sgn_t (
        .clk   (clk),
        .rst_n (rst_n),
        .set_i (sgn_set),
        .clr_i (clr_ok),
        .q_o   (sgn_t)
    );

    // Bit taint only reaches the add/sub strobes; the schedule never depends on it.
    assign strobe_t = in_bit ? taint_or(taint_or(ctrl_t, sgn_t), multiplierReg_t[cnt_q])
                             : ctrl_t;

    assign busy_t        = ctrl_t;
    assign productDone_t = ctrl_t;
    assign rsclear_t     = ctrl_t;
    assign rsshr_t       = ctrl_t;
    assign mrld_t        = ctrl_t;
    assign mdld_t        = ctrl_t;
    assign rsload_t      = strobe_t;
    assign rssub_t       = strobe_t;
`else
    logic unused_taint;
    assign unused_taint = ^{start_t, abort_t, signed_mode_t, taint_clr, multiplierReg_t};

    assign busy_t        = 1'b0;
    assign productDone_t = 1'b0;
    assign rsclear_t     = 1'b0;
    assign rsshr_t       = 1'b0;
    assign mrld_t        = 1'b0;
    assign mdld_t        = 1'b0;
    assign rsload_t      = 1'b0;
    assign rssub_t       = 1'b0;
`endif

endmodule

// File: tb/tb_mult_ctrl_taint_param.sv
// Directed bench for mult_ctrl_taint_param (WIDTH=4) with hand-computed strobe tables.
// Strobe vector order: {busy, productDone, rsload, rssub, rsclear, rsshr, mrld, mdld}.
module tb_mult_ctrl_taint_param;

    localparam int WIDTH = 4;

`ifdef MULT_TAINT_EN
    localparam logic [7:0] TMASK = 8'hFF;
`else
    localparam logic [7:0] TMASK = 8'h00;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start, start_t, abort, abort_t;
    logic             signed_mode, signed_mode_t, taint_clr;
    logic [WIDTH-1:0] multiplierReg, multiplierReg_t;
    logic busy, busy_t, productDone, productDone_t;
    logic rsload, rsload_t, rssub, rssub_t, rsclear, rsclear_t;
    logic rsshr, rsshr_t, mrld, mrld_t, mdld, mdld_t;

    mult_ctrl_taint_param #(.WIDTH(WIDTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .start_t         (start_t),
        .abort           (abort),
        .abort_t         (abort_t),
        .signed_mode     (signed_mode),
        .signed_mode_t   (signed_mode_t),
        .taint_clr       (taint_clr),
        .multiplierReg   (multiplierReg),
        .multiplierReg_t (multiplierReg_t),
        .busy            (busy),
        .busy_t          (busy_t),
        .productDone     (productDone),
        .productDone_t   (productDone_t),
        .rsload          (rsload),
        .rsload_t        (rsload_t),
        .rssub           (rssub),
        .rssub_t         (rssub_t),
        .rsclear         (rsclear),
        .rsclear_t       (rsclear_t),
        .rsshr           (rsshr),
        .rsshr_t         (rsshr_t),
        .mrld            (mrld),
        .mrld_t          (mrld_t),
        .mdld            (mdld),
        .mdld_t          (mdld_t)
    );

    always #5 clk = ~clk;

    logic [7:0] strobes, taints;
    assign strobes = {busy, productDone, rsload, rssub, rsclear, rsshr, mrld, mdld};
    assign taints  = {busy_t, productDone_t, rsload_t, rssub_t, rsclear_t, rsshr_t, mrld_t, mdld_t};

    logic [7:0] exp_q  [0:11];
    logic [7:0] texp_q [0:11];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start a run at edge 0 and compare cycles 1..11 against the tables.
    task automatic run_seq(input string tag, input logic [3:0] mr, input logic sm, input logic hold);
        multiplierReg = mr;
        signed_mode   = sm;
        start         = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            step();
            start = hold && (i < 9);
            check($sformatf("%s.s%0d", tag, i), 32'(strobes), 32'(exp_q[i]));
            check($sformatf("%s.t%0d", tag, i), 32'(taints), 32'(texp_q[i] & TMASK));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0; start_t = 1'b0; abort = 1'b0; abort_t = 1'b0;
        signed_mode = 1'b0; signed_mode_t = 1'b0; taint_clr = 1'b0;
        multiplierReg = '0; multiplierReg_t = '0;

        #12;
        check("rst.s", 32'(strobes), 32'h0);
        check("rst.t", 32'(taints), 32'h0);
        rst_n = 1'b1;
        step();

        // Unsigned 1011: rsload in BIT cycles 1,1,0,1; done in cycle 10.
        exp_q  = '{8'h00, 8'h8B, 8'hA0, 8'h84, 8'hA0, 8'h84, 8'h80, 8'h84, 8'hA0, 8'h84, 8'hC0, 8'h00};
        texp_q = '{default: 8'h00};
        run_seq("unsg", 4'b1011, 1'b0, 1'b0);

        // Start held high while busy must not disturb the schedule.
        run_seq("hold", 4'b1011, 1'b0, 1'b1);

        // Signed 1101: rsload, -, rsload, rssub.
        exp_q = '{8'h00, 8'h8B, 8'hA0, 8'h84, 8'h80, 8'h84, 8'hA0, 8'h84, 8'h90, 8'h84, 8'hC0, 8'h00};
        run_seq("sgnd", 4'b1101, 1'b1, 1'b0);

        // Abort during the second SHIFT.
        exp_q = '{8'h00, 8'h8B, 8'hA0, 8'h84, 8'hA0, 8'h84, 8'h80, 8'h84, 8'hA0, 8'h84, 8'hC0, 8'h00};
        multiplierReg = 4'b1011;
        signed_mode   = 1'b0;
        start         = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            start = 1'b0;
        end
        check("ab.shift2", 32'(strobes), 32'h84);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("ab.idle", 32'(strobes), 32'h0);
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("ab.quiet%0d", i), 32'(strobes), 32'h0);
        end
        run_seq("ab.rerun", 4'b1011, 1'b0, 1'b0);

        // Start and abort together in IDLE: abort wins.
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check("ab_st.s", 32'(strobes), 32'h0);
        check("ab_st.t", 32'(taints), 32'h0);
        step();
        check("ab_st.s2", 32'(strobes), 32'h0);

        // Multiplier-bit taint reaches only the add/sub strobes in the 3rd BIT.
        multiplierReg_t = 4'b0100;
        texp_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h30, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_seq("t_bit", 4'b1011, 1'b0, 1'b0);
        multiplierReg_t = '0;

        // Tainted start taints every control output, sticky into IDLE.
        start_t = 1'b1;
        texp_q  = '{default: 8'hFF};
        run_seq("t_start", 4'b1011, 1'b0, 1'b0);
        start_t = 1'b0;
        step();
        check("t_stick", 32'(taints), 32'(8'hFF & TMASK));
        taint_clr = 1'b1;
        step();
        taint_clr = 1'b0;
        check("t_clr", 32'(taints), 32'h0);

        // Abort taint is collected even when abort is a no-op in IDLE.
        abort   = 1'b1;
        abort_t = 1'b1;
        step();
        abort   = 1'b0;
        abort_t = 1'b0;
        check("t_abort.s", 32'(strobes), 32'h0);
        check("t_abort.t", 32'(taints), 32'(8'hFF & TMASK));

        // Clear and untainted start in the same cycle: run starts clean.
        taint_clr     = 1'b1;
        start         = 1'b1;
        multiplierReg = 4'b1011;
        step();
        taint_clr = 1'b0;
        start     = 1'b0;
        check("clr_start.s", 32'(strobes), 32'h8B);
        check("clr_start.t", 32'(taints), 32'h0);

        // Asynchronous reset in the middle of a BIT cycle.
        step();
        check("arst.bit", 32'(strobes), 32'hA0);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst.s", 32'(strobes), 32'h0);
        check("arst.t", 32'(taints), 32'h0);
        #2;
        rst_n = 1'b1;
        step();
        check("arst.idle", 32'(strobes), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
